// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: op encodings, bus widths, FSM states
// and small decode helpers used by both the stage and its lane aligner.
package mem_stage_pkg;

    localparam int MEM_OP_BUS  = 4;
    localparam int BYTE_EN_BUS = 4;

    typedef enum logic [MEM_OP_BUS-1:0] {
        MEM_OP_NONE = 4'd0,
        MEM_OP_LB   = 4'd1,
        MEM_OP_LBU  = 4'd2,
        MEM_OP_LH   = 4'd3,
        MEM_OP_LHU  = 4'd4,
        MEM_OP_LW   = 4'd5,
        MEM_OP_SB   = 4'd6,
        MEM_OP_SH   = 4'd7,
        MEM_OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_BUSY = 1'b1
    } mem_state_e;

    // Undefined encodings behave exactly like NONE.
    function automatic mem_op_e decode_op(input logic [MEM_OP_BUS-1:0] raw);
        mem_op_e op;
        op = (raw > 4'd8) ? MEM_OP_NONE : mem_op_e'(raw);
        return op;
    endfunction

    function automatic logic is_store(input mem_op_e op);
        return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
    endfunction

    function automatic logic misaligned(input mem_op_e op, input logic [1:0] lo);
        logic bad;
        case (op)
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: bad = lo[0];
            MEM_OP_LW, MEM_OP_SW:             bad = |lo;
            default:                          bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store strobes/replicated data and sign/zero-extended load data.
// Latency: purely combinational.
// Backpressure: none.
module mem_lane_align
    import mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  mem_op_e                op,
    input  logic [1:0]             addr_lo,
    input  logic [DATA_WIDTH-1:0]  st_data,
    input  logic [DATA_WIDTH-1:0]  ld_raw,
    output logic [BYTE_EN_BUS-1:0] byte_en,
    output logic [DATA_WIDTH-1:0]  st_lanes,
    output logic [DATA_WIDTH-1:0]  ld_ext
);

    localparam int LANE_W = DATA_WIDTH / BYTE_EN_BUS;
    localparam int HALF_W = 2 * LANE_W;

    logic [LANE_W-1:0] ld_byte;
    logic [HALF_W-1:0] ld_half;

    always_comb begin
        ld_byte  = ld_raw[addr_lo*LANE_W +: LANE_W];
        ld_half  = addr_lo[1] ? ld_raw[DATA_WIDTH-1 -: HALF_W] : ld_raw[HALF_W-1:0];
        byte_en  = '0;
        st_lanes = '0;
        ld_ext   = '0;
        case (op)
            MEM_OP_SB: begin
                byte_en  = BYTE_EN_BUS'(1) << addr_lo;
                st_lanes = {BYTE_EN_BUS{st_data[LANE_W-1:0]}};
            end
            MEM_OP_SH: begin
                byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
                st_lanes = {2{st_data[HALF_W-1:0]}};
            end
            MEM_OP_SW: begin
                byte_en  = '1;
                st_lanes = st_data;
            end
            MEM_OP_LB:  ld_ext = {{(DATA_WIDTH-LANE_W){ld_byte[LANE_W-1]}}, ld_byte};
            MEM_OP_LBU: ld_ext = {{(DATA_WIDTH-LANE_W){1'b0}}, ld_byte};
            MEM_OP_LH:  ld_ext = {{(DATA_WIDTH-HALF_W){ld_half[HALF_W-1]}}, ld_half};
            MEM_OP_LHU: ld_ext = {{(DATA_WIDTH-HALF_W){1'b0}}, ld_half};
            MEM_OP_LW:  ld_ext = ld_raw;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// EX->WB memory stage: aligned load/store over a request/ack RAM port.
// Latency: 1 cycle for non-memory ops; 2 + ack wait cycles for memory ops.
// Backpressure: stall_req holds EX from acceptance until the cycle ram_ack arrives.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ex_valid,
    input  logic [MEM_OP_BUS-1:0]     mem_op,
    input  logic [DATA_WIDTH-1:0]     result_in,
    input  logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic                      write_reg_en_in,
    input  logic [REG_ADDR_WIDTH-1:0] write_reg_addr_in,
    input  logic                      flush,
    output logic                      stall_req,
    output logic                      ram_en,
    output logic [BYTE_EN_BUS-1:0]    ram_we,
    output logic [DATA_WIDTH-1:0]     ram_addr,
    output logic [DATA_WIDTH-1:0]     ram_wdata,
    input  logic [DATA_WIDTH-1:0]     ram_rdata,
    input  logic                      ram_ack,
    output logic                      wb_valid,
    output logic [DATA_WIDTH-1:0]     result_out,
    output logic                      write_reg_en_out,
    output logic [REG_ADDR_WIDTH-1:0] write_reg_addr_out,
    output logic                      addr_err
);

    mem_state_e                state_q, state_d;
    mem_op_e                   op_q, op_d, op_in;
    logic [DATA_WIDTH-1:0]     addr_q, addr_d, wdata_q, wdata_d;
    logic                      wen_q, wen_d, drop_q, drop_d;
    logic [REG_ADDR_WIDTH-1:0] waddr_q, waddr_d;

    logic                      wb_valid_d, wen_out_d, addr_err_d;
    logic [DATA_WIDTH-1:0]     result_d;
    logic [REG_ADDR_WIDTH-1:0] waddr_out_d;

    logic                      busy, accept, drop_now;
    logic [BYTE_EN_BUS-1:0]    lane_we;
    logic [DATA_WIDTH-1:0]     lane_wdata, lane_load;

    mem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
        .op       (op_q),
        .addr_lo  (addr_q[1:0]),
        .st_data  (wdata_q),
        .ld_raw   (ram_rdata),
        .byte_en  (lane_we),
        .st_lanes (lane_wdata),
        .ld_ext   (lane_load)
    );

    assign op_in     = decode_op(mem_op);
    assign busy      = (state_q == MEM_BUSY);
    // Qualified with rst so stall_req also drops combinationally during reset.
    assign accept    = rst && ex_valid && !flush;
    assign drop_now  = drop_q || flush;

    assign ram_en    = busy;
    assign ram_we    = busy ? lane_we : '0;
    assign ram_addr  = busy ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
    assign ram_wdata = (busy && is_store(op_q)) ? lane_wdata : '0;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wen_d       = wen_q;
        waddr_d     = waddr_q;
        drop_d      = drop_q;
        wb_valid_d  = 1'b0;
        wen_out_d   = 1'b0;
        addr_err_d  = 1'b0;
        result_d    = result_out;
        waddr_out_d = write_reg_addr_out;
        stall_req   = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (accept) begin
                    if (op_in == MEM_OP_NONE) begin
                        wb_valid_d  = 1'b1;
                        result_d    = result_in;
                        wen_out_d   = write_reg_en_in;
                        waddr_out_d = write_reg_addr_in;
                    end else if (misaligned(op_in, result_in[1:0])) begin
                        wb_valid_d  = 1'b1;
                        addr_err_d  = 1'b1;
                        result_d    = result_in;
                        waddr_out_d = write_reg_addr_in;
                    end else begin
                        op_d      = op_in;
                        addr_d    = result_in;
                        wdata_d   = mem_wdata;
                        wen_d     = write_reg_en_in;
                        waddr_d   = write_reg_addr_in;
                        drop_d    = 1'b0;
                        state_d   = MEM_BUSY;
                        stall_req = 1'b1;
                    end
                end
            end
            MEM_BUSY: begin
                stall_req = !ram_ack;
                if (flush) drop_d = 1'b1;
                if (ram_ack) begin
                    state_d     = MEM_IDLE;
                    drop_d      = 1'b0;
                    wb_valid_d  = !drop_now;
                    wen_out_d   = !drop_now && !is_store(op_q) && wen_q;
                    result_d    = is_store(op_q) ? addr_q : lane_load;
                    waddr_out_d = waddr_q;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q            <= MEM_IDLE;
            op_q               <= MEM_OP_NONE;
            addr_q             <= '0;
            wdata_q            <= '0;
            wen_q              <= 1'b0;
            waddr_q            <= '0;
            drop_q             <= 1'b0;
            wb_valid           <= 1'b0;
            result_out         <= '0;
            write_reg_en_out   <= 1'b0;
            write_reg_addr_out <= '0;
            addr_err           <= 1'b0;
        end else begin
            state_q            <= state_d;
            op_q               <= op_d;
            addr_q             <= addr_d;
            wdata_q            <= wdata_d;
            wen_q              <= wen_d;
            waddr_q            <= waddr_d;
            drop_q             <= drop_d;
            wb_valid           <= wb_valid_d;
            result_out         <= result_d;
            write_reg_en_out   <= wen_out_d;
            write_reg_addr_out <= waddr_out_d;
            addr_err           <= addr_err_d;
        end
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of EX, upstream of WB.
- Takes the EX result, register write info and memory-op info; performs aligned load/store over a simple request/ack data-RAM port; sign/zero-extends load data.
- Drives the registered EX→WB outputs and raises a stall request while a RAM access is outstanding.
- Non-memory instructions pass through with 1-cycle latency.

Parameters:
- DATA_WIDTH, 32, datapath and RAM data width; byte lanes fixed at 4.
- REG_ADDR_WIDTH, 5, register-file address width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX presents a valid instruction
- mem_op  in  4  NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8; others treated as NONE
- result_in  in  32  EX result; byte address for memory ops
- mem_wdata  in  32  store data (rt value)
- write_reg_en_in  in  1  register write enable from EX
- write_reg_addr_in  in  5  destination register from EX
- flush  in  1  discard current instruction
- stall_req  out  1  upstream must hold inputs this cycle
- ram_en  out  1  RAM request
- ram_we  out  4  byte write strobes, 0000 = read
- ram_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- ram_wdata  out  32  lane-replicated store data
- ram_rdata  in  32  read data, valid with ram_ack
- ram_ack  in  1  access complete, ≥0 cycles after ram_en rises
- wb_valid  out  1  WB outputs valid
- result_out  out  32  ALU result or extended load data
- write_reg_en_out  out  1  register write enable to WB
- write_reg_addr_out  out  5  destination register to WB
- addr_err  out  1  one-cycle misalignment pulse; result_out carries the faulting address

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; ram_en drops immediately; any in-flight access is abandoned.
- FSM states:
  - IDLE:
    - ex_valid && !flush && mem_op==NONE: next edge latches wb_valid=1, result_out=result_in, write_reg_en/addr passed through; stall_req=0.
    - Aligned memory op: latch address, op, wdata and reg info; go to BUSY. stall_req=1 combinationally in this cycle.
    - Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0): no access. Next edge: wb_valid=1, write_reg_en_out=0, addr_err=1, result_out=address. Stay IDLE; stall_req=0.
    - ex_valid=0 or flush=1: next edge wb_valid=0, write_reg_en_out=0, addr_err=0.
  - BUSY:
    - ram_en=1; ram_we/ram_addr/ram_wdata come from latched values, stable until ack.
    - stall_req = !ram_ack.
    - On ram_ack: next edge loads WB outputs, returns to IDLE. Loads write extended data with write_reg_en_out = latched enable; stores force write_reg_en_out=0.
    - Back-to-back: an ack cycle permits a new IDLE-style acceptance in the following cycle only (no same-cycle overlap).
    - flush while BUSY: sets a drop flag. Access still completes (no bus abort); the ack cycle produces wb_valid=0.
- Store lanes, k=addr[1:0], little-endian:
  - SB: we=1<<k; wdata = byte replicated ×4.
  - SH: we=0011 (k=0) or 1100 (k=2); wdata = halfword replicated ×2.
  - SW: we=1111.
- Load extraction: byte k or halfword k[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW takes the word.
- Outputs registered except stall_req and the ram_* request signals.
- ram_ack while IDLE: ignored.
- wb_valid, addr_err: single-cycle unless refreshed by a new instruction.

Decomposition:
- Shared package/define file (alongside the existing bus/funct defines):
  - MEM_OP_* encodings and MEM_OP_BUS width.
  - BYTE_EN_BUS.
  - FSM state encodings (MEM_IDLE, MEM_BUSY).
- One natural sub-module: mem_lane_align. Purely combinational; computes ram_we/ram_wdata from op and addr, and extended load data from rdata. Instantiated once for stores and once for loads, or as a single dual-function module.

Test Plan:
- Pass-through: mem_op=NONE, result_in=0x0000_00FF, en=1, addr=5 → next cycle wb_valid=1, result_out=0xFF, write_reg_addr_out=5; stall_req never 1.
- LB sign-extend: addr=0x1003, rdata=0x80xx_xxxx, ack 2 cycles after ram_en → ram_addr=0x1000, we=0000, stall_req high 3 cycles, result_out=0xFFFF_FF80. Repeat with LBU → 0x0000_0080.
- SH upper: addr=0x2002, wdata=0x1234_ABCD, zero-wait ack → ram_we=1100, ram_wdata=0xABCD_ABCD, write_reg_en_out=0.
- Misaligned LW: addr=0x3001 → ram_en stays 0; next cycle addr_err=1, result_out=0x3001, write_reg_en_out=0.
- Flush during BUSY: LW in flight, flush=1, ack 3 cycles later → ram_en held until ack; wb_valid=0 after ack.
- Async reset mid-access: rst=0 while BUSY → ram_en, stall_req, wb_valid drop to 0 without a clock edge. After release, a NONE op completes normally.
